// File: rtl/cache_mem_pkg.sv
// Shared types, widths and helpers for the cache miss responder.
package cache_mem_pkg;

  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned WORDS_PER_BLK = 8;
  localparam int unsigned BLK_OFF_W     = 4;
  localparam int unsigned WORD_IDX_W    = 3;
  localparam int unsigned WORD_BYTES    = 2;
  localparam int unsigned CNT_W         = WORD_IDX_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, FILL_DC, FILL_IC} state_t;

  // Request priority: store beats D fill beats I fill.
  function automatic state_t pick_req(input logic dc_wr, input logic dc_miss,
                                      input logic ic_miss);
    state_t nxt;
    nxt = IDLE;
    if (dc_wr)        nxt = WRITE;
    else if (dc_miss) nxt = FILL_DC;
    else if (ic_miss) nxt = FILL_IC;
    return nxt;
  endfunction

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:BLK_OFF_W], BLK_OFF_W'(0)};
  endfunction

endpackage

// File: rtl/fill_sequencer.sv
// Block-fill bookkeeping: base latch, read-issue counter and return counter.
module fill_sequencer
  import cache_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic                  issue,
  input  logic                  ret,
  output logic [ADDR_W-1:0]     issue_addr,
  output logic [WORD_IDX_W-1:0] ret_word,
  output logic                  issue_done,
  output logic                  last_return
);

  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  ret_cnt;

  // The start cycle itself issues word 0, so the issue count begins at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (start) begin
      base      <= block_base(start_addr);
      issue_cnt <= CNT_W'(1);
      ret_cnt   <= '0;
    end else begin
      if (issue && !issue_done) issue_cnt <= issue_cnt + CNT_W'(1);
      if (ret && !ret_cnt[CNT_W-1]) ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end

  assign issue_addr  = base + ADDR_W'(issue_cnt) * ADDR_W'(WORD_BYTES);
  assign issue_done  = (issue_cnt == CNT_W'(WORDS_PER_BLK));
  assign last_return = (ret_cnt == CNT_W'(WORDS_PER_BLK - 1));
  assign ret_word    = ret_cnt[WORD_IDX_W-1:0];

endmodule

// File: rtl/cache_mem_ctrl.sv
// Services I/D-cache block fills and D-cache write-through stores against main memory.
module cache_mem_ctrl
  import cache_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_miss,
  input  logic [ADDR_W-1:0]     ic_miss_addr,
  input  logic                  dc_miss,
  input  logic [ADDR_W-1:0]     dc_miss_addr,
  input  logic                  dc_wr,
  input  logic [ADDR_W-1:0]     dc_wr_addr,
  input  logic [DATA_W-1:0]     dc_wr_data,
  output logic [DATA_W-1:0]     fill_data,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic                  ic_fill_valid,
  output logic                  dc_fill_valid,
  output logic                  ic_done,
  output logic                  dc_done,
  output logic                  dc_wr_ack,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid
);

  state_t                state;
  state_t                req_state;
  logic                  fill_active;
  logic                  start;
  logic [ADDR_W-1:0]     start_addr;
  logic                  accept;
  logic [ADDR_W-1:0]     issue_addr;
  logic [WORD_IDX_W-1:0] ret_word;
  logic                  issue_done;
  logic                  last_return;

  assign req_state   = pick_req(dc_wr, dc_miss, ic_miss);
  assign fill_active = (state == FILL_DC) || (state == FILL_IC);
  assign start       = (state == IDLE) && ((req_state == FILL_DC) || (req_state == FILL_IC));
  assign start_addr  = (req_state == FILL_DC) ? dc_miss_addr : ic_miss_addr;
  assign accept      = fill_active && mem_rvalid;

  fill_sequencer u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .issue       (fill_active),
    .ret         (accept),
    .issue_addr  (issue_addr),
    .ret_word    (ret_word),
    .issue_done  (issue_done),
    .last_return (last_return)
  );

  // State and registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      dc_wr_ack <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      dc_wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          state <= req_state;
          case (req_state)
            WRITE: begin
              mem_en    <= 1'b1;
              mem_wr    <= 1'b1;
              mem_addr  <= dc_wr_addr;
              mem_wdata <= dc_wr_data;
              dc_wr_ack <= 1'b1;
            end
            FILL_DC, FILL_IC: begin
              mem_en   <= 1'b1;
              mem_addr <= block_base(start_addr);
            end
            default: ;
          endcase
        end
        WRITE: state <= IDLE;
        FILL_DC, FILL_IC: begin
          if (!issue_done) begin
            mem_en   <= 1'b1;
            mem_addr <= issue_addr;
          end
          if (mem_rvalid && last_return) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Returned words pass straight through to the owning cache; stray returns are dropped.
  assign busy          = (state != IDLE);
  assign fill_data     = accept ? mem_rdata : '0;
  assign fill_word     = accept ? ret_word : '0;
  assign ic_fill_valid = accept && (state == FILL_IC);
  assign dc_fill_valid = accept && (state == FILL_DC);
  assign ic_done       = ic_fill_valid && last_return;
  assign dc_done       = dc_fill_valid && last_return;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl with a fixed-latency pipelined memory model.
module tb_cache_mem_ctrl;

  localparam int unsigned MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_miss, dc_miss, dc_wr;
  logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        ic_fill_valid, dc_fill_valid, ic_done, dc_done, dc_wr_ack, busy;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;

  logic [MEM_LAT-1:0] pv = '0;
  logic [15:0]        pd [MEM_LAT];
  logic               inj_v = 1'b0;
  logic [15:0]        inj_d = 16'h0;

  int n_assert = 0;
  int n_fail   = 0;

  cache_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
    .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
    .dc_wr(dc_wr), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .fill_data(fill_data), .fill_word(fill_word),
    .ic_fill_valid(ic_fill_valid), .dc_fill_valid(dc_fill_valid),
    .ic_done(ic_done), .dc_done(dc_done), .dc_wr_ack(dc_wr_ack), .busy(busy),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  // Memory: word at byte address A reads back as A ^ 0xA5A5, MEM_LAT cycles after issue.
  always @(posedge clk) begin
    pv[0] <= mem_en && !mem_wr;
    pd[0] <= mem_addr ^ 16'hA5A5;
    for (int i = 1; i < MEM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end

  assign mem_rvalid = pv[MEM_LAT-1] | inj_v;
  assign mem_rdata  = inj_v ? inj_d : pd[MEM_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single I fill from the current cycle (cycle 0); checks cycles 1..14.
  task automatic run_ic_fill(input logic [15:0] addr);
    logic [15:0] base;
    base = {addr[15:4], 4'h0};
    ic_miss = 1'b1;
    ic_miss_addr = addr;
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk("ic_mem_en", 32'(mem_en), 32'(c >= 1 && c <= 8));
      if (c <= 8) begin
        chk("ic_mem_addr", 32'(mem_addr), 32'(base + 16'(2 * (c - 1))));
        chk("ic_mem_wr", 32'(mem_wr), 32'd0);
      end
      chk("ic_fill_valid", 32'(ic_fill_valid), 32'(c >= 5 && c <= 12));
      chk("ic_dc_valid", 32'(dc_fill_valid), 32'd0);
      if (c >= 5 && c <= 12) begin
        chk("ic_fill_word", 32'(fill_word), 32'(c - 5));
        chk("ic_fill_data", 32'(fill_data), 32'((base + 16'(2 * (c - 5))) ^ 16'hA5A5));
      end
      chk("ic_done", 32'(ic_done), 32'(c == 12));
      chk("ic_busy", 32'(busy), 32'(c <= 12));
      if (c == 12) ic_miss = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ic_miss = 1'b0; dc_miss = 1'b0; dc_wr = 1'b0;
    ic_miss_addr = '0; dc_miss_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_ack", 32'(dc_wr_ack), 32'd0);
    chk("rst_ic_valid", 32'(ic_fill_valid), 32'd0);
    chk("rst_dc_valid", 32'(dc_fill_valid), 32'd0);
    chk("rst_fill_data", 32'(fill_data), 32'd0);
    chk("rst_done", 32'({ic_done, dc_done}), 32'd0);
    rst_n = 1'b1;
    tick();

    // I-cache fill of 0x1236
    run_ic_fill(16'h1236);

    // Write-through store
    dc_wr = 1'b1; dc_wr_addr = 16'h0040; dc_wr_data = 16'hBEEF;
    tick();
    chk("wr_mem_en", 32'(mem_en), 32'd1);
    chk("wr_mem_wr", 32'(mem_wr), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h0040);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("wr_ack", 32'(dc_wr_ack), 32'd1);
    chk("wr_busy1", 32'(busy), 32'd1);
    dc_wr = 1'b0;
    tick();
    chk("wr_busy2", 32'(busy), 32'd0);
    chk("wr_ack2", 32'(dc_wr_ack), 32'd0);
    chk("wr_mem_en2", 32'(mem_en), 32'd0);
    tick();

    // Simultaneous D and I misses: D first, then I after one IDLE cycle
    ic_miss = 1'b1; ic_miss_addr = 16'h0100;
    dc_miss = 1'b1; dc_miss_addr = 16'h2000;
    for (int c = 1; c <= 26; c++) begin
      tick();
      chk("both_dc_valid", 32'(dc_fill_valid), 32'(c >= 5 && c <= 12));
      chk("both_dc_done", 32'(dc_done), 32'(c == 12));
      chk("both_ic_valid", 32'(ic_fill_valid), 32'(c >= 18 && c <= 25));
      chk("both_ic_done", 32'(ic_done), 32'(c == 25));
      chk("both_mem_en", 32'(mem_en), 32'((c >= 1 && c <= 8) || (c >= 14 && c <= 21)));
      chk("both_busy", 32'(busy), 32'((c >= 1 && c <= 12) || (c >= 14 && c <= 25)));
      if (c >= 1 && c <= 8)
        chk("both_dc_addr", 32'(mem_addr), 32'(16'h2000 + 16'(2 * (c - 1))));
      if (c >= 14 && c <= 21)
        chk("both_ic_addr", 32'(mem_addr), 32'(16'h0100 + 16'(2 * (c - 14))));
      if (c == 5) chk("both_dc_data0", 32'(fill_data), 32'h85A5);
      if (c == 18) chk("both_ic_data0", 32'(fill_data), 32'hA4A5);
      if (c == 25) chk("both_ic_word7", 32'(fill_word), 32'd7);
      if (c == 12) dc_miss = 1'b0;
      if (c == 25) ic_miss = 1'b0;
    end

    // Store and D miss arrive mid I fill: order ic_done, dc_wr_ack, dc_done
    ic_miss = 1'b1; ic_miss_addr = 16'h3450;
    for (int c = 1; c <= 29; c++) begin
      tick();
      chk("ord_ic_done", 32'(ic_done), 32'(c == 12));
      chk("ord_wr_ack", 32'(dc_wr_ack), 32'(c == 14));
      chk("ord_dc_done", 32'(dc_done), 32'(c == 27));
      if (c == 14) begin
        chk("ord_wr_mem_wr", 32'(mem_wr), 32'd1);
        chk("ord_wr_addr", 32'(mem_addr), 32'h0044);
        chk("ord_wr_data", 32'(mem_wdata), 32'h1234);
      end
      if (c == 16) begin
        chk("ord_dc_en", 32'(mem_en), 32'd1);
        chk("ord_dc_addr", 32'(mem_addr), 32'h4000);
      end
      if (c == 20) begin
        chk("ord_dc_valid", 32'(dc_fill_valid), 32'd1);
        chk("ord_dc_data", 32'(fill_data), 32'hE5A5);
        chk("ord_dc_word", 32'(fill_word), 32'd0);
      end
      if (c == 3) begin
        dc_wr = 1'b1; dc_wr_addr = 16'h0044; dc_wr_data = 16'h1234;
        dc_miss = 1'b1; dc_miss_addr = 16'h4008;
      end
      if (c == 12) ic_miss = 1'b0;
      if (c == 14) dc_wr = 1'b0;
      if (c == 27) dc_miss = 1'b0;
    end

    // Reset at cycle 6 of an I fill; late returns must be dropped
    ic_miss = 1'b1; ic_miss_addr = 16'h1236;
    for (int c = 1; c <= 6; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ic_miss = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_mem_en", 32'(mem_en), 32'd0);
    chk("mrst_ic_valid", 32'(ic_fill_valid), 32'd0);
    chk("mrst_fill_data", 32'(fill_data), 32'd0);
    for (int c = 8; c <= 11; c++) begin
      tick();
      chk("mrst_late_valid", 32'(ic_fill_valid), 32'd0);
      chk("mrst_late_done", 32'(ic_done), 32'd0);
      chk("mrst_late_busy", 32'(busy), 32'd0);
    end
    run_ic_fill(16'h1236);

    // Spurious returns in IDLE and in WRITE
    inj_v = 1'b1; inj_d = 16'h5555;
    #1;
    chk("spur_idle_ic", 32'(ic_fill_valid), 32'd0);
    chk("spur_idle_dc", 32'(dc_fill_valid), 32'd0);
    chk("spur_idle_data", 32'(fill_data), 32'd0);
    tick();
    chk("spur_idle_busy", 32'(busy), 32'd0);
    inj_v = 1'b0;
    dc_wr = 1'b1; dc_wr_addr = 16'h0002; dc_wr_data = 16'h0001;
    tick();
    inj_v = 1'b1;
    #1;
    chk("spur_wr_ack", 32'(dc_wr_ack), 32'd1);
    chk("spur_wr_dc", 32'(dc_fill_valid), 32'd0);
    inj_v = 1'b0;
    dc_wr = 1'b0;
    tick();
    chk("spur_wr_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
